// File: rtl/tnn_pkg.sv
// Shared definitions for the temporal-neural-network neuron blocks.
//   GAMMA_CYCLE_WIDTH_DEFAULT : default aclk cycles per gamma cycle
//   WEIGHT_WIDTH_DEFAULT      : default bits per synaptic weight
//   neuron_state_e            : neuron firing state (accumulating / fired)
//   pot_width()               : potential width that can hold the largest
//                               possible sum of fully ramped inputs
package tnn_pkg;

  localparam int GAMMA_CYCLE_WIDTH_DEFAULT = 32'sd16;
  localparam int WEIGHT_WIDTH_DEFAULT      = 32'sd3;

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_FIRED = 1'b1
  } neuron_state_e;

  // Every input can contribute at most 2^W-1, so this width never overflows.
  function automatic int pot_width(input int num_inputs, input int weight_width);
    return $clog2(num_inputs * ((32'sd1 <<< weight_width) - 32'sd1) + 32'sd1);
  endfunction

endpackage

// File: rtl/srm0_ramp.sv
// Per-synapse ramp for the SRM0 neuron.
//   aclk   : clock
//   grst   : asynchronous active-low reset
//   spike  : delayed spike edge for this synapse (level, sticky once seen)
//   clear  : end-of-gamma-cycle clear, wins over a simultaneous arrival
//   wreg   : latched weight, i.e. the height the ramp climbs to
//   inc    : high on an edge where the ramp steps up by one
module srm0_ramp #(
  parameter int WEIGHT_WIDTH = 32'sd3
) (
  input  logic                    aclk,
  input  logic                    grst,
  input  logic                    spike,
  input  logic                    clear,
  input  logic [WEIGHT_WIDTH-1:0] wreg,
  output logic                    inc
);

  logic                    active_r;
  logic [WEIGHT_WIDTH-1:0] ramp_r;
  logic                    inc_s;

  // Ramp climbs one step per edge once active, stopping at the weight;
  // a zero weight therefore never contributes.
  always_comb begin
    inc_s = active_r && (ramp_r < wreg);
  end

  assign inc = inc_s;

  // Sticky arrival flag and ramp counter, both cleared at gamma-cycle end.
  always_ff @(posedge aclk or negedge grst) begin
    if (!grst) begin
      active_r <= 1'b0;
      ramp_r   <= '0;
    end else if (clear) begin
      active_r <= 1'b0;
      ramp_r   <= '0;
    end else begin
      if (spike) begin
        active_r <= 1'b1;
      end
      if (inc_s) begin
        ramp_r <= ramp_r + WEIGHT_WIDTH'(1'b1);
      end
    end
  end

endmodule

// File: rtl/srm0_neuron.sv
// SRM0 spiking neuron with ramp-no-leak response over a gamma cycle.
//   aclk        : clock, all state on posedge
//   grst        : asynchronous active-low reset
//   in          : delayed spike edges, bit i high once spike i has arrived
//   weight      : per-input ramp heights, packed NUM_INPUTS x WEIGHT_WIDTH
//   threshold   : firing threshold, 0 disables firing
//   out         : output spike edge, held high to the end of the gamma cycle
//   spike_time  : gamma count of the first cycle out is high
//   gamma_start : high while the gamma count is 0
// Weight and threshold are sampled once per gamma cycle (at count 0) so
// upstream may change them freely mid-cycle.
module srm0_neuron
  import tnn_pkg::*;
#(
  parameter int NUM_INPUTS        = 32'sd8,
  parameter int GAMMA_CYCLE_WIDTH = GAMMA_CYCLE_WIDTH_DEFAULT,
  parameter int WEIGHT_WIDTH      = WEIGHT_WIDTH_DEFAULT,
  localparam int POT_WIDTH        = pot_width(NUM_INPUTS, WEIGHT_WIDTH),
  localparam int CNT_WIDTH        = $clog2(GAMMA_CYCLE_WIDTH)
) (
  input  logic                               aclk,
  input  logic                               grst,
  input  logic [NUM_INPUTS-1:0]              in,
  input  logic [NUM_INPUTS*WEIGHT_WIDTH-1:0] weight,
  input  logic [POT_WIDTH-1:0]               threshold,
  output logic                               out,
  output logic [CNT_WIDTH-1:0]               spike_time,
  output logic                               gamma_start
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(GAMMA_CYCLE_WIDTH - 32'sd1);

  logic [CNT_WIDTH-1:0]                     gamma_cnt_r;
  logic                                     last_s;
  logic [NUM_INPUTS-1:0][WEIGHT_WIDTH-1:0]  wreg_r;
  logic [POT_WIDTH-1:0]                     treg_r;
  logic [NUM_INPUTS-1:0]                    inc_s;
  logic [POT_WIDTH-1:0]                     inc_cnt_s;
  logic [POT_WIDTH-1:0]                     potential_r;
  logic [POT_WIDTH-1:0]                     pot_nxt_s;
  neuron_state_e                            state_r;
  neuron_state_e                            state_nxt_s;
  logic                                     fire_s;
  logic                                     out_r;
  logic [CNT_WIDTH-1:0]                     spike_time_r;
  logic                                     gamma_start_r;

  assign last_s = (gamma_cnt_r == CNT_LAST);

  // Gamma counter plus a registered copy of "count is zero".
  always_ff @(posedge aclk or negedge grst) begin
    if (!grst) begin
      gamma_cnt_r   <= '0;
      gamma_start_r <= 1'b1;
    end else begin
      gamma_cnt_r   <= last_s ? '0 : gamma_cnt_r + CNT_WIDTH'(1'b1);
      gamma_start_r <= last_s;
    end
  end

  // Weights and threshold are sampled only at the start of a gamma cycle.
  always_ff @(posedge aclk or negedge grst) begin
    if (!grst) begin
      wreg_r <= '0;
      treg_r <= '0;
    end else if (gamma_cnt_r == '0) begin
      wreg_r <= weight;
      treg_r <= threshold;
    end
  end

  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_syn
    srm0_ramp #(
      .WEIGHT_WIDTH(WEIGHT_WIDTH)
    ) u_ramp (
      .aclk (aclk),
      .grst (grst),
      .spike(in[gi]),
      .clear(last_s),
      .wreg (wreg_r[gi]),
      .inc  (inc_s[gi])
    );
  end

  // Adder tree: potential grows by the number of ramps stepping this edge.
  always_comb begin
    inc_cnt_s = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      inc_cnt_s = inc_cnt_s + POT_WIDTH'(inc_s[i]);
    end
    pot_nxt_s = potential_r + inc_cnt_s;
  end

  // Membrane potential, discarded at the end of every gamma cycle.
  always_ff @(posedge aclk or negedge grst) begin
    if (!grst) begin
      potential_r <= '0;
    end else if (last_s) begin
      potential_r <= '0;
    end else begin
      potential_r <= pot_nxt_s;
    end
  end

  // Firing FSM state register.
  always_ff @(posedge aclk or negedge grst) begin
    if (!grst) begin
      state_r <= ST_ACCUM;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Firing decision: compare the post-edge potential so the spike lands on
  // the same edge the threshold is reached; end-of-cycle clear takes priority.
  always_comb begin
    state_nxt_s = state_r;
    fire_s      = 1'b0;
    if (last_s) begin
      state_nxt_s = ST_ACCUM;
    end else begin
      case (state_r)
        ST_ACCUM: begin
          if ((treg_r != '0) && (pot_nxt_s >= treg_r)) begin
            fire_s      = 1'b1;
            state_nxt_s = ST_FIRED;
          end else begin
            state_nxt_s = ST_ACCUM;
          end
        end
        ST_FIRED: state_nxt_s = ST_FIRED;
        default:  state_nxt_s = ST_ACCUM;
      endcase
    end
  end

  // Output spike and its timestamp, held until the gamma cycle ends.
  always_ff @(posedge aclk or negedge grst) begin
    if (!grst) begin
      out_r        <= 1'b0;
      spike_time_r <= '0;
    end else if (last_s) begin
      out_r        <= 1'b0;
      spike_time_r <= '0;
    end else if (fire_s) begin
      out_r        <= 1'b1;
      spike_time_r <= gamma_cnt_r + CNT_WIDTH'(1'b1);
    end
  end

  assign out         = out_r;
  assign spike_time  = spike_time_r;
  assign gamma_start = gamma_start_r;

endmodule

// File: doc/srm0_neuron.md
SRM0_NEURON -- requirements
Module: srm0_neuron

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 8: number of synaptic inputs fed by upstream delay stages.
REQ-002 SHALL have parameter GAMMA_CYCLE_WIDTH, default 16: aclk cycles per gamma cycle.
REQ-003 SHALL have parameter WEIGHT_WIDTH, default 3: bits per synaptic weight.
REQ-004 SHALL have port aclk, input, 1 bit: single clock; all state on posedge.
REQ-005 SHALL have port grst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port in, input, NUM_INPUTS bits: delayed spike edges; bit i high means spike i has arrived.
REQ-007 SHALL have port weight, input, NUM_INPUTS x WEIGHT_WIDTH bits: per-input ramp height.
REQ-008 SHALL have port threshold, input, POT_WIDTH bits: firing threshold; 0 disables firing.
REQ-009 SHALL have port out, output, 1 bit: output spike edge, held high until end of gamma cycle.
REQ-010 SHALL have port spike_time, output, clog2(GAMMA_CYCLE_WIDTH) bits: gamma_cnt value of the first cycle out is high.
REQ-011 SHALL have port gamma_start, output, 1 bit: high while gamma_cnt == 0.

Function
REQ-012 SHALL keep gamma_cnt counting 0..GAMMA_CYCLE_WIDTH-1, +1 per aclk, wrapping to 0.
REQ-013 SHALL latch weight and threshold into registers at the edge where gamma_cnt == 0; mid-cycle input changes ignored.
REQ-014 SHALL set sticky active[i] at any edge where in[i]==1 and gamma_cnt != GAMMA_CYCLE_WIDTH-1.
REQ-015 SHALL hold per-input ramp[i] (WEIGHT_WIDTH bits); at each edge where active[i] and ramp[i] < wreg[i], ramp[i] += 1.
REQ-016 SHALL update potential by adding the count of inputs incremented at that edge; first increment at edge k+1 after in[i] sampled at edge k.
REQ-017 SHALL size potential as POT_WIDTH = clog2(NUM_INPUTS*(2^WEIGHT_WIDTH-1)+1); no saturation needed, overflow impossible.
REQ-018 SHALL implement FSM states ACCUM and FIRED; ACCUM -> FIRED at edge where next potential >= treg and treg != 0.
REQ-019 SHALL at that edge set out=1 and spike_time=gamma_cnt+1; FIRED holds out, spike_time unchanged; at most one fire per gamma cycle.
REQ-020 SHALL at edge where gamma_cnt == GAMMA_CYCLE_WIDTH-1 clear active, ramp, potential, out, spike_time, FSM->ACCUM; clear wins over simultaneous fire or arrival.
REQ-021 SHALL treat weight 0 inputs as non-contributing; an input already high at gamma_cnt==0 is active from that edge.

Reset
REQ-022 SHALL on grst low asynchronously force gamma_cnt=0, out=0, spike_time=0, potential=0, ramps=0, active=0, wreg=0, treg=0, FSM=ACCUM.
REQ-023 SHALL after grst release start a gamma cycle at gamma_cnt=0; reset mid-cycle discards partial accumulation.

Structure
REQ-024 SHALL place GAMMA_CYCLE_WIDTH, WEIGHT_WIDTH defaults, POT_WIDTH function and the FSM state enum in shared package tnn_pkg.
REQ-025 SHALL instantiate sub-module srm0_ramp per input (active flag, ramp counter, increment bit); adder tree and FSM in top.

Verification
REQ-026 SHALL cover: treg=3, in[0] high from gamma_cnt=2, w0=4 -> potential 1,2,3 after edges 3,4,5; out high at gamma_cnt=6, spike_time=6.
REQ-027 SHALL cover: treg=4, in[0],in[1] both high at gamma_cnt=1, w=2 each -> potential 2 then 4; out high at gamma_cnt=4, spike_time=4.
REQ-028 SHALL cover: treg=5, single input w=3 -> potential plateaus at 3, out never rises; all state cleared after gamma_cnt=15.
REQ-029 SHALL cover: fire in cycle N, inputs held high into cycle N+1 -> out low at gamma_cnt=0, refires with same timing in N+1.
REQ-030 SHALL cover: grst low at gamma_cnt=7 after active inputs -> outputs 0 immediately; next cycle starts at gamma_cnt=0 on release.
REQ-031 SHALL cover: threshold changed at gamma_cnt=5 -> no effect until next gamma_cnt=0; treg=0 -> out never rises.
